uart_tx_arbiter: RTL and testbench

- Shares one uart_tx instance between N byte-producing requesters using round-robin arbitration.
- Drives the transmitter's send strobe and data bus, and sequences each frame by watching the transmitter's ready flag.
- Flags a timeout when the transmitter never accepts a frame.
- Sits between on-board data sources (switch capture, loopback echo, status reporter) and the transmitter.

---
 rtl/uart_tx_arbiter_pkg.sv | 19 +
 rtl/uart_tx_arbiter_rr_select.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 103 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter: FSM state encoding and a
// constant-width helper used to size index and counter fields.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SEND       = 2'd1,
    WAIT_START = 2'd2,
    WAIT_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Round-robin pick: rotate the valid vector to start just past the last
// grant, take the lowest set bit, then map it back to a requester index.
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_valid,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  function automatic logic [W-1:0] wrap(input int v);
    return W'(v % N);
  endfunction

  logic [N-1:0] rot;
  logic [W-1:0] pick;

  always_comb begin
    rot  = '0;
    pick = '0;
    for (int i = 0; i < N; i++) rot[i] = req_valid[wrap(int'(last) + 1 + i)];
    // Walk downward so the lowest rotated index is the one left standing.
    for (int i = N - 1; i >= 0; i--) if (rot[i]) pick = W'(i);
    any_valid = |req_valid;
    winner    = wrap(int'(last) + 1 + int'(pick));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between N byte sources, round-robin, and
// sequences each frame off the transmitter's ready flag with a lost-frame timeout.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int N       = 4,
  parameter  int TIMEOUT = 64,
  localparam int GW      = clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_valid,
  input  logic [8*N-1:0]  req_data,
  output logic [N-1:0]    req_ready,
  input  logic            uart_ready,
  output logic            uart_send,
  output logic [7:0]      uart_data,
  output logic [GW-1:0]   grant_id,
  output logic            busy,
  output logic            err_timeout,
  input  logic            err_clr
);

  localparam int CW = clog2(TIMEOUT) + 1;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [N-1:0]    ready_n;
  logic            send_n, err_n;
  logic [7:0]      data_n;
  logic [GW-1:0]   gid_n, winner;
  logic            any_valid;

  rr_select #(.N(N), .W(GW)) u_sel (
    .req_valid (req_valid),
    .last      (grant_id),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_ready   <= '0;
      uart_send   <= 1'b0;
      uart_data   <= '0;
      grant_id    <= GW'(N - 1);
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      req_ready   <= ready_n;
      uart_send   <= send_n;
      uart_data   <= data_n;
      grant_id    <= gid_n;
      err_timeout <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ready_n = '0;
    send_n  = 1'b0;
    data_n  = uart_data;
    gid_n   = grant_id;
    err_n   = err_timeout & ~err_clr;
    unique case (state)
      IDLE: begin
        if (uart_ready && any_valid) begin
          data_n          = req_data[8*winner +: 8];
          gid_n           = winner;
          ready_n[winner] = 1'b1;
          send_n          = 1'b1;
          state_n         = SEND;
        end
      end
      SEND: begin
        cnt_n   = '0;
        state_n = WAIT_START;
      end
      WAIT_START: begin
        if (!uart_ready) begin
          state_n = WAIT_DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          // Frame never started: drop it; a same-cycle clear loses to the set.
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (uart_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: N=4, TIMEOUT=64, transmitter ready flag
// driven by hand in each step.
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        uart_ready = 1'b0;
  logic        uart_send;
  logic [7:0]  uart_data;
  logic [1:0]  grant_id;
  logic        busy;
  logic        err_timeout;
  logic        err_clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_ready  (uart_ready),
    .uart_send   (uart_send),
    .uart_data   (uart_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout),
    .err_clr     (err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send();
    int k;
    k = 0;
    while (uart_send !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    chk("send_seen", {31'd0, uart_send}, 32'd1);
  endtask

  // One frame with a well-behaved transmitter: ready drops 2 cycles after send.
  task automatic frame(input logic [7:0] exp_data, input logic [1:0] exp_gid);
    wait_send();
    chk("frame_data", {24'd0, uart_data}, {24'd0, exp_data});
    chk("frame_gid", {30'd0, grant_id}, {30'd0, exp_gid});
    chk("frame_req_ready", {28'd0, req_ready}, 32'd1 << exp_gid);
    step();
    chk("frame_pulse_once", {27'd0, req_ready, uart_send}, 32'd0);
    uart_ready = 1'b0;
    step(); step(); step();
    chk("frame_busy_mid", {31'd0, busy}, 32'd1);
    uart_ready = 1'b1;
    step();
    chk("frame_idle_after", {31'd0, busy}, 32'd0);
    chk("frame_data_hold", {24'd0, uart_data}, {24'd0, exp_data});
  endtask

  initial begin
    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_send", {31'd0, uart_send}, 32'd0);
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_data", {24'd0, uart_data}, 32'd0);
    chk("rst_gid", {30'd0, grant_id}, 32'd3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    step(); step();
    rst = 1'b1;
    step();

    // Single requester 2, send exactly one edge after request seen
    req_data   = 32'h00A5_0000;
    req_valid  = 4'b0100;
    uart_ready = 1'b1;
    step();
    chk("single_send_latency", {31'd0, uart_send}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    frame(8'hA5, 2'd2);
    req_valid = '0;

    // All four valid; last grant was 2, so rotation starts at 3
    req_data  = 32'h1312_1110;
    req_valid = 4'b1111;
    frame(8'h13, 2'd3);
    frame(8'h10, 2'd0);
    frame(8'h11, 2'd1);
    frame(8'h12, 2'd2);
    frame(8'h13, 2'd3);
    req_valid = '0;

    // Wrap-around from grant 3
    req_valid = 4'b0011;
    frame(8'h10, 2'd0);
    frame(8'h11, 2'd1);
    req_valid = '0;

    // Transmitter busy while idle: nothing may be granted
    uart_ready = 1'b0;
    req_valid  = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_send", {31'd0, uart_send}, 32'd0);
      chk("hold_req_ready", {28'd0, req_ready}, 32'd0);
    end
    uart_ready = 1'b1;
    step();
    chk("hold_release_send", {31'd0, uart_send}, 32'd1);
    frame(8'h10, 2'd0);
    req_valid = '0;

    // Timeout: ready never falls
    req_valid = 4'b0001;
    wait_send();
    req_valid = '0;
    for (int i = 0; i < T; i++) step();
    chk("to_not_yet", {31'd0, err_timeout}, 32'd0);
    chk("to_busy_before", {31'd0, busy}, 32'd1);
    step();
    chk("to_set", {31'd0, err_timeout}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    err_clr = 1'b1;
    step();
    chk("to_clear", {31'd0, err_timeout}, 32'd0);

    // Timeout with clear held through the setting edge: set wins
    req_valid = 4'b0001;
    wait_send();
    req_valid = '0;
    for (int i = 0; i < T; i++) step();
    chk("to2_not_yet", {31'd0, err_timeout}, 32'd0);
    step();
    chk("to2_set_wins", {31'd0, err_timeout}, 32'd1);
    err_clr = 1'b0;
    step();
    chk("to2_sticky", {31'd0, err_timeout}, 32'd1);

    // Reset during WAIT_DONE
    req_valid = 4'b0100;
    wait_send();
    chk("mid_gid", {30'd0, grant_id}, 32'd2);
    req_valid = '0;
    step();
    uart_ready = 1'b0;
    step();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_gid", {30'd0, grant_id}, 32'd3);
    chk("mid_rst_data", {24'd0, uart_data}, 32'd0);
    chk("mid_rst_err", {31'd0, err_timeout}, 32'd0);
    chk("mid_rst_send", {27'd0, req_ready, uart_send}, 32'd0);
    req_valid = 4'b1111;
    #2 rst = 1'b1;
    step(); step();
    chk("post_rst_wait", {31'd0, uart_send}, 32'd0);
    uart_ready = 1'b1;
    step();
    chk("post_rst_send", {31'd0, uart_send}, 32'd1);
    chk("post_rst_gid", {30'd0, grant_id}, 32'd0);
    chk("post_rst_data", {24'd0, uart_data}, 32'h10);
    req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
